tlk2711_rx_deframer: RTL and testbench
======================================

Name: tlk2711_rx_deframer

Overview:
- Receive-side link stage directly downstream of the TLK2711 RXD/RKMSB/RKLSB pins.
- Qualifies link sync from idle/comma words and strips SOF/length/checksum/EOF framing.
- Emits payload as a 16-bit valid-only beat stream to the RX DMA write FIFO.
- Produces loss-of-sync, frame-done and frame-error pulses for the IRQ lines.
- Runs on the fabric clock; the RX pins are treated as synchronous to it.

Parameters:
- MAX_LEN, 4096: maximum payload words per frame.
- LOCK_CNT, 4: consecutive idle words required to declare lock.
- LOSS_CNT, 8: consecutive code-error words that drop lock.
- IDLE_WORD, 16'hC5BC: idle pattern; valid only with rklsb=1, rkmsb=0.
- SOF_WORD, 16'hFBFB: start of frame; valid only with rkmsb=1, rklsb=1.
- EOF_WORD, 16'hFDFD: end of frame; valid only with rkmsb=1, rklsb=1.

Ports:
- clk  in  1  fabric clock; all logic rising-edge.
- arst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  0 forces UNLOCK and blocks all outputs.
- i_cnt_clr  in  1  synchronous clear of o_frame_cnt and o_err_cnt.
- i_2711_rkmsb  in  1  K flag, MSB byte.
- i_2711_rklsb  in  1  K flag, LSB byte.
- i_2711_rxd  in  16  received word.
- m_tvalid  out  1  payload beat valid; the sink always accepts.
- m_tdata  out  16  payload word.
- m_tlast  out  1  last beat of frame.
- m_tuser  out  1  frame bad; meaningful only when m_tlast=1.
- o_locked  out  1  link lock status.
- o_loss_irq  out  1  1-cycle pulse on a locked-to-unlocked transition.
- o_frame_irq  out  1  1-cycle pulse on a good frame.
- o_err_irq  out  1  1-cycle pulse on a frame error.
- o_err_code  out  3  last error code; held until the next error.
- o_last_len  out  16  length field of the last good frame.
- o_frame_cnt  out  16  good frame count; saturating.
- o_err_cnt  out  16  error count; saturating.

Behaviour:
- Reset: all outputs 0; state UNLOCK.
- Input handling: the three RX inputs are registered once before decode.
- Word classes:
  - IDLE: matches IDLE_WORD with its K flags.
  - SOF, EOF: match their words with their K flags.
  - DATA: both K flags 0.
  - CODEERR: any other K-flag/data combination.
- Lock:
  - In UNLOCK, count consecutive IDLE words; any other class clears the count.
  - Reaching LOCK_CNT gives o_locked=1 and state HUNT.
  - While locked, count consecutive CODEERR words; any non-CODEERR word clears the count.
  - Reaching LOSS_CNT gives o_locked=0, one o_loss_irq pulse, and state UNLOCK.
- HUNT:
  - SOF moves to LEN.
  - IDLE, DATA and EOF are ignored.
  - CODEERR only feeds the loss counter.
- LEN: accepts the next DATA word as length L.
  - L=0 or L>MAX_LEN: error code 3, return to HUNT.
  - Otherwise clear the checksum, set remaining = L, go to DATA.
- DATA:
  - Each DATA word adds to a 16-bit checksum (mod 2^16) and decrements remaining.
  - When remaining reaches 0, go to CSUM.
- CSUM: the next DATA word is compared with the accumulated sum; mismatch is error code 4. Go to EOF.
- EOF state:
  - EOF word: frame complete. If no error, one o_frame_irq pulse, o_last_len=L, o_frame_cnt+1.
  - Any other non-IDLE word: error code 5, back to HUNT. A SOF also starts a new frame directly in LEN.
- IDLE words inside LEN/DATA/CSUM/EOF are fill: ignored, no count, no checksum contribution.
- In-frame errors:
  - CODEERR: code 1.
  - SOF or EOF seen in LEN or DATA: code 2.
  - Loss of lock mid-frame: code 6.
  - Each aborts the frame to HUNT; loss of lock aborts to UNLOCK instead.
- Output hold register (payload beats are delayed by one accepted word):
  - Payload word k is held and emitted (m_tvalid=1 for 1 cycle) when the next accepted DATA/CSUM word is registered.
  - Last payload word is emitted when CSUM is registered, with m_tlast=1 and m_tuser = checksum mismatch.
  - On abort with a held word: that word is emitted the next cycle with m_tlast=1, m_tuser=1.
  - On abort with no held word: nothing is emitted.
- Every error:
  - One o_err_irq pulse.
  - o_err_code updated.
  - o_err_cnt+1.
- Counters: saturate at 16'hFFFF. i_cnt_clr wins over a simultaneous increment.
- i_enable=0: immediate UNLOCK; the held word is dropped with no beat; no IRQs.
- Latency: non-last payload beat appears 2 cycles after the following word is on the pins, with no idle fill between.

Test Plan:
- 6 × IDLE after reset: o_locked rises on the 4th idle (+1 input register cycle); no IRQs.
- Locked, then SOF, L=3, 0x0001, 0x0002, 0x0003, csum 0x0006, EOF:
  - 3 beats; last beat has m_tlast=1, m_tuser=0.
  - o_frame_irq pulse, o_last_len=3, o_frame_cnt=1.
- Same frame with csum 0x0007: last beat m_tuser=1, o_err_code=4, o_err_cnt=1, no o_frame_irq.
- SOF, L=4, two data words, then CODEERR (rkmsb=1, rxd=16'h1234):
  - 1st word emitted normally; 2nd emitted with m_tlast=1, m_tuser=1.
  - o_err_code=1; state HUNT.
- Locked, 8 consecutive CODEERR words: o_locked=0 plus one o_loss_irq pulse; 7 errors followed by 1 idle keeps lock.
- Edge cases:
  - L=0 and L=4097: code 3, no beats.
  - IDLE inserted between payload words: identical output beats and checksum.
  - arst_n asserted mid-frame: all outputs 0 immediately.

Source files
------------

// File: rtl/tlk2711_rx_deframer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tlk2711_rx_deframer : TLK2711 receive link sync, frame strip, payload beats |
// | rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tlk2711_rx_deframer #(
    parameter int          MAX_LEN   = 4096,
    parameter int          LOCK_CNT  = 4,
    parameter int          LOSS_CNT  = 8,
    parameter logic [15:0] IDLE_WORD = 16'hC5BC,
    parameter logic [15:0] SOF_WORD  = 16'hFBFB,
    parameter logic [15:0] EOF_WORD  = 16'hFDFD
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        i_enable,
    input  logic        i_cnt_clr,
    input  logic        i_2711_rkmsb,
    input  logic        i_2711_rklsb,
    input  logic [15:0] i_2711_rxd,
    output logic        m_tvalid,
    output logic [15:0] m_tdata,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic        o_locked,
    output logic        o_loss_irq,
    output logic        o_frame_irq,
    output logic        o_err_irq,
    output logic [2:0]  o_err_code,
    output logic [15:0] o_last_len,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_err_cnt
);

    localparam int LKW = $clog2(LOCK_CNT + 1);
    localparam int LSW = $clog2(LOSS_CNT + 1);

    localparam logic [2:0] S_UNLOCK = 3'd0;
    localparam logic [2:0] S_HUNT   = 3'd1;
    localparam logic [2:0] S_LEN    = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_EOF    = 3'd5;

    logic           r_rkmsb, r_rklsb;
    logic [15:0]    r_rxd;
    logic [2:0]     r_state;
    logic [LKW-1:0] r_lock_cnt;
    logic [LSW-1:0] r_loss_cnt;
    logic [15:0]    r_len, r_rem, r_csum, r_hold;
    logic           r_hold_vld, r_bad;

    logic           w_idle, w_sof, w_eof, w_data, w_cerr, w_mismatch;
    logic [2:0]     w_state_nxt, w_err_code;
    logic [LKW-1:0] w_lock_cnt_nxt;
    logic [LSW-1:0] w_loss_cnt_nxt;
    logic           w_err, w_good, w_loss, w_abort, w_accept, w_csum_word, w_len_ok;

    assign w_idle     = (r_rxd == IDLE_WORD) && !r_rkmsb && r_rklsb;
    assign w_sof      = (r_rxd == SOF_WORD) && r_rkmsb && r_rklsb;
    assign w_eof      = (r_rxd == EOF_WORD) && r_rkmsb && r_rklsb;
    assign w_data     = !r_rkmsb && !r_rklsb;
    assign w_cerr     = !(w_idle || w_sof || w_eof || w_data);
    assign w_mismatch = (r_rxd != r_csum);

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_loss_cnt_nxt = r_loss_cnt;
        w_err          = 1'b0;
        w_err_code     = 3'd0;
        w_good         = 1'b0;
        w_loss         = 1'b0;
        w_abort        = 1'b0;
        w_accept       = 1'b0;
        w_csum_word    = 1'b0;
        w_len_ok       = 1'b0;
        if (r_state == S_UNLOCK) begin
            if (!w_idle) begin
                w_lock_cnt_nxt = '0;
            end else if (r_lock_cnt == LKW'(LOCK_CNT - 1)) begin
                w_lock_cnt_nxt = '0;
                w_state_nxt    = S_HUNT;
            end else begin
                w_lock_cnt_nxt = r_lock_cnt + LKW'(1);
            end
        end else begin
            w_loss_cnt_nxt = w_cerr ? r_loss_cnt + LSW'(1) : '0;
            if (w_cerr && (r_loss_cnt == LSW'(LOSS_CNT - 1))) begin
                w_loss         = 1'b1;
                w_loss_cnt_nxt = '0;
                w_state_nxt    = S_UNLOCK;
                if (r_state != S_HUNT) begin
                    w_err      = 1'b1;
                    w_err_code = 3'd6;
                    w_abort    = 1'b1;
                end
            end else if (r_state == S_HUNT) begin
                if (w_sof) w_state_nxt = S_LEN;
            end else if (!w_idle) begin
                // Frame states: idle words are fill and fall through untouched
                case (r_state)
                    S_LEN: begin
                        if (w_data) begin
                            if ((r_rxd == 16'd0) || (r_rxd > 16'(MAX_LEN))) begin
                                w_err = 1'b1; w_err_code = 3'd3; w_state_nxt = S_HUNT;
                            end else begin
                                w_len_ok = 1'b1; w_state_nxt = S_DATA;
                            end
                        end else begin
                            w_err = 1'b1; w_err_code = w_cerr ? 3'd1 : 3'd2; w_state_nxt = S_HUNT;
                        end
                    end
                    S_DATA, S_CSUM: begin
                        if (w_data) begin
                            if (r_state == S_CSUM) begin
                                w_csum_word = 1'b1;
                                w_state_nxt = S_EOF;
                                if (w_mismatch) begin
                                    w_err = 1'b1; w_err_code = 3'd4;
                                end
                            end else begin
                                w_accept = 1'b1;
                                if (r_rem == 16'd1) w_state_nxt = S_CSUM;
                            end
                        end else begin
                            w_err = 1'b1; w_err_code = w_cerr ? 3'd1 : 3'd2;
                            w_abort = 1'b1; w_state_nxt = S_HUNT;
                        end
                    end
                    S_EOF: begin
                        if (w_eof) begin
                            w_good = !r_bad; w_state_nxt = S_HUNT;
                        end else begin
                            w_err = 1'b1; w_err_code = w_cerr ? 3'd1 : 3'd5;
                            w_state_nxt = w_sof ? S_LEN : S_HUNT;
                        end
                    end
                    default: w_state_nxt = S_HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rkmsb <= 1'b0; r_rklsb <= 1'b0; r_rxd <= '0;
            r_state <= S_UNLOCK; r_lock_cnt <= '0; r_loss_cnt <= '0;
            r_len <= '0; r_rem <= '0; r_csum <= '0; r_hold <= '0;
            r_hold_vld <= 1'b0; r_bad <= 1'b0;
            m_tvalid <= 1'b0; m_tdata <= '0; m_tlast <= 1'b0; m_tuser <= 1'b0;
            o_locked <= 1'b0; o_loss_irq <= 1'b0; o_frame_irq <= 1'b0; o_err_irq <= 1'b0;
            o_err_code <= '0; o_last_len <= '0;
        end else begin
            r_rkmsb     <= i_2711_rkmsb;
            r_rklsb     <= i_2711_rklsb;
            r_rxd       <= i_2711_rxd;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            m_tuser     <= 1'b0;
            o_loss_irq  <= 1'b0;
            o_frame_irq <= 1'b0;
            o_err_irq   <= 1'b0;
            if (!i_enable) begin
                r_state    <= S_UNLOCK;
                r_lock_cnt <= '0;
                r_loss_cnt <= '0;
                r_hold_vld <= 1'b0;
                o_locked   <= 1'b0;
            end else begin
                r_state     <= w_state_nxt;
                r_lock_cnt  <= w_lock_cnt_nxt;
                r_loss_cnt  <= w_loss_cnt_nxt;
                o_locked    <= (w_state_nxt != S_UNLOCK);
                o_loss_irq  <= w_loss;
                o_frame_irq <= w_good;
                o_err_irq   <= w_err;
                if (w_err)  o_err_code <= w_err_code;
                if (w_good) o_last_len <= r_len;
                if (w_len_ok) begin
                    r_len  <= r_rxd;
                    r_rem  <= r_rxd;
                    r_csum <= '0;
                    r_bad  <= 1'b0;
                end
                // Payload is held one word so the final beat can carry tlast/tuser
                if (w_accept) begin
                    r_csum     <= r_csum + r_rxd;
                    r_rem      <= r_rem - 16'd1;
                    r_hold     <= r_rxd;
                    r_hold_vld <= 1'b1;
                    if (r_hold_vld) begin
                        m_tvalid <= 1'b1;
                        m_tdata  <= r_hold;
                    end
                end
                if (w_csum_word) begin
                    r_bad      <= w_mismatch;
                    r_hold_vld <= 1'b0;
                    m_tvalid   <= 1'b1;
                    m_tdata    <= r_hold;
                    m_tlast    <= 1'b1;
                    m_tuser    <= w_mismatch;
                end
                if (w_abort && r_hold_vld) begin
                    r_hold_vld <= 1'b0;
                    m_tvalid   <= 1'b1;
                    m_tdata    <= r_hold;
                    m_tlast    <= 1'b1;
                    m_tuser    <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_frame_cnt <= '0;
            o_err_cnt   <= '0;
        end else if (i_cnt_clr) begin
            o_frame_cnt <= '0;
            o_err_cnt   <= '0;
        end else begin
            if (i_enable && w_good && (o_frame_cnt != 16'hFFFF)) o_frame_cnt <= o_frame_cnt + 16'd1;
            if (i_enable && w_err && (o_err_cnt != 16'hFFFF))    o_err_cnt   <= o_err_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tlk2711_rx_deframer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_tlk2711_rx_deframer : vector-table bench for the TLK2711 RX deframer     |
// | rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_tlk2711_rx_deframer;

    localparam logic [1:0] KI = 2'b01;  // {rkmsb, rklsb}
    localparam logic [1:0] KK = 2'b11;
    localparam logic [1:0] KD = 2'b00;
    localparam logic [1:0] KE = 2'b10;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        i_enable = 1'b1;
    logic        i_cnt_clr = 1'b0;
    logic        i_2711_rkmsb = 1'b0;
    logic        i_2711_rklsb = 1'b0;
    logic [15:0] i_2711_rxd = '0;
    logic        m_tvalid, m_tlast, m_tuser;
    logic [15:0] m_tdata;
    logic        o_locked, o_loss_irq, o_frame_irq, o_err_irq;
    logic [2:0]  o_err_code;
    logic [15:0] o_last_len, o_frame_cnt, o_err_cnt;

    int n_chk = 0;
    int n_err = 0;
    int n_loss = 0;
    int n_eirq = 0;

    always #5 clk = ~clk;

    tlk2711_rx_deframer dut (
        .clk(clk), .arst_n(arst_n), .i_enable(i_enable), .i_cnt_clr(i_cnt_clr),
        .i_2711_rkmsb(i_2711_rkmsb), .i_2711_rklsb(i_2711_rklsb), .i_2711_rxd(i_2711_rxd),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .o_locked(o_locked), .o_loss_irq(o_loss_irq), .o_frame_irq(o_frame_irq),
        .o_err_irq(o_err_irq), .o_err_code(o_err_code), .o_last_len(o_last_len),
        .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
    );

    // Expected columns describe the outputs seen when the row is applied,
    // i.e. the effect of the row two entries earlier.
    typedef struct {
        logic [1:0]  k;
        logic [15:0] d;
        logic        ev;
        logic [15:0] ed;
        logic        el, eu, lk, fi, ei;
        logic [2:0]  ec;
    } row_t;

    row_t tbl[$];

    function automatic row_t r(input logic [1:0] k, input logic [15:0] d, input logic ev,
                               input logic [15:0] ed, input logic el, input logic eu,
                               input logic lk, input logic fi, input logic ei,
                               input logic [2:0] ec);
        row_t x;
        x.k = k; x.d = d; x.ev = ev; x.ed = ed; x.el = el; x.eu = eu;
        x.lk = lk; x.fi = fi; x.ei = ei; x.ec = ec;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [1:0] k, input logic [15:0] d);
        @(negedge clk);
        {i_2711_rkmsb, i_2711_rklsb} = k;
        i_2711_rxd = d;
    endtask

    always @(negedge clk) begin
        if (arst_n) begin
            n_loss += int'(o_loss_irq);
            n_eirq += int'(o_err_irq);
        end
    end

    initial begin
        int loss0, eirq0;
        // k, d, ev, ed, el, eu, lk, fi, ei, ec
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 0, 0, 0, 0));  // 0
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 0, 0, 0));  // 5 lock from 4th idle
        tbl.push_back(r(KK, 16'hFBFB, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(r(KD, 16'd3,    0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(r(KD, 16'd1,    0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(r(KD, 16'd2,    0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(r(KD, 16'd3,    0, 0, 0, 0, 1, 0, 0, 0));  // 10
        tbl.push_back(r(KD, 16'd6,    1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(r(KK, 16'hFDFD, 1, 2, 0, 0, 1, 0, 0, 0));
        tbl.push_back(r(KI, 16'hC5BC, 1, 3, 1, 0, 1, 0, 0, 0));
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 0, 0, 0));  // 15
        tbl.push_back(r(KK, 16'hFBFB, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(r(KD, 16'd3,    0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(r(KD, 16'd1,    0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(r(KD, 16'd2,    0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(r(KD, 16'd3,    0, 0, 0, 0, 1, 0, 0, 0));  // 20
        tbl.push_back(r(KD, 16'd7,    1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(r(KK, 16'hFDFD, 1, 2, 0, 0, 1, 0, 0, 0));
        tbl.push_back(r(KI, 16'hC5BC, 1, 3, 1, 1, 1, 0, 1, 4));
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 0, 0, 4));
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 0, 0, 4));  // 25
        tbl.push_back(r(KK, 16'hFBFB, 0, 0, 0, 0, 1, 0, 0, 4));
        tbl.push_back(r(KD, 16'd3,    0, 0, 0, 0, 1, 0, 0, 4));
        tbl.push_back(r(KD, 16'd1,    0, 0, 0, 0, 1, 0, 0, 4));
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 0, 0, 4));
        tbl.push_back(r(KD, 16'd2,    0, 0, 0, 0, 1, 0, 0, 4));  // 30
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 0, 0, 4));
        tbl.push_back(r(KD, 16'd3,    1, 1, 0, 0, 1, 0, 0, 4));
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 0, 0, 4));
        tbl.push_back(r(KD, 16'd6,    1, 2, 0, 0, 1, 0, 0, 4));
        tbl.push_back(r(KK, 16'hFDFD, 0, 0, 0, 0, 1, 0, 0, 4));  // 35
        tbl.push_back(r(KI, 16'hC5BC, 1, 3, 1, 0, 1, 0, 0, 4));
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 1, 0, 4));
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 0, 0, 4));
        tbl.push_back(r(KK, 16'hFBFB, 0, 0, 0, 0, 1, 0, 0, 4));
        tbl.push_back(r(KD, 16'd0,    0, 0, 0, 0, 1, 0, 0, 4));  // 40 L=0
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 0, 0, 4));
        tbl.push_back(r(KK, 16'hFBFB, 0, 0, 0, 0, 1, 0, 1, 3));
        tbl.push_back(r(KD, 16'd4097, 0, 0, 0, 0, 1, 0, 0, 3));  // L>MAX_LEN
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 0, 0, 3));
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 0, 1, 3));  // 45
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 0, 0, 3));
        tbl.push_back(r(KK, 16'hFBFB, 0, 0, 0, 0, 1, 0, 0, 3));
        tbl.push_back(r(KD, 16'd4,    0, 0, 0, 0, 1, 0, 0, 3));
        tbl.push_back(r(KD, 16'h000A, 0, 0, 0, 0, 1, 0, 0, 3));
        tbl.push_back(r(KD, 16'h000B, 0, 0, 0, 0, 1, 0, 0, 3));  // 50
        tbl.push_back(r(KE, 16'h1234, 0, 0, 0, 0, 1, 0, 0, 3));
        tbl.push_back(r(KI, 16'hC5BC, 1, 16'h000A, 0, 0, 1, 0, 0, 3));
        tbl.push_back(r(KI, 16'hC5BC, 1, 16'h000B, 1, 1, 1, 0, 1, 1));
        tbl.push_back(r(KI, 16'hC5BC, 0, 0, 0, 0, 1, 0, 0, 1));

        repeat (3) @(negedge clk);
        chk("reset_locked", o_locked, 0);
        chk("reset_tvalid", m_tvalid, 0);
        chk("reset_frame_cnt", o_frame_cnt, 0);
        chk("reset_err_code", o_err_code, 0);
        arst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            chk($sformatf("row%0d_locked", i), o_locked, tbl[i].lk);
            chk($sformatf("row%0d_tvalid", i), m_tvalid, tbl[i].ev);
            chk($sformatf("row%0d_frame_irq", i), o_frame_irq, tbl[i].fi);
            chk($sformatf("row%0d_err_irq", i), o_err_irq, tbl[i].ei);
            chk($sformatf("row%0d_err_code", i), o_err_code, tbl[i].ec);
            chk($sformatf("row%0d_loss_irq", i), o_loss_irq, 0);
            if (tbl[i].ev) begin
                chk($sformatf("row%0d_tdata", i), m_tdata, tbl[i].ed);
                chk($sformatf("row%0d_tlast", i), m_tlast, tbl[i].el);
                chk($sformatf("row%0d_tuser", i), m_tuser, tbl[i].eu);
            end
            {i_2711_rkmsb, i_2711_rklsb} = tbl[i].k;
            i_2711_rxd = tbl[i].d;
        end
        @(negedge clk);
        chk("frame_cnt", o_frame_cnt, 2);
        chk("err_cnt", o_err_cnt, 4);
        chk("last_len", o_last_len, 3);

        // 7 code errors then an idle must not drop lock
        loss0 = n_loss; eirq0 = n_eirq;
        repeat (7) send(KE, 16'h1234);
        repeat (3) send(KI, 16'hC5BC);
        @(negedge clk); #1;
        chk("keep_lock", o_locked, 1);
        chk("keep_lock_no_loss_irq", n_loss - loss0, 0);

        repeat (8) send(KE, 16'h1234);
        repeat (3) send(KI, 16'hC5BC);
        @(negedge clk); #1;
        chk("loss_locked", o_locked, 0);
        chk("loss_irq_count", n_loss - loss0, 1);
        chk("loss_no_err_irq", n_eirq - eirq0, 0);
        chk("loss_err_cnt", o_err_cnt, 4);

        repeat (6) send(KI, 16'hC5BC);
        @(negedge clk);
        chk("relock", o_locked, 1);
        i_cnt_clr = 1'b1;
        @(negedge clk);
        i_cnt_clr = 1'b0;
        chk("clr_frame_cnt", o_frame_cnt, 0);
        chk("clr_err_cnt", o_err_cnt, 0);

        // Async reset while a payload beat is on the output
        send(KK, 16'hFBFB);
        send(KD, 16'd2);
        send(KD, 16'd5);
        send(KD, 16'd6);
        send(KI, 16'hC5BC);
        @(negedge clk);
        chk("pre_rst_tvalid", m_tvalid, 1);
        chk("pre_rst_tdata", m_tdata, 5);
        arst_n = 1'b0;
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_locked", o_locked, 0);
        chk("rst_err_code", o_err_code, 0);
        chk("rst_last_len", o_last_len, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
